// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_pkg
//  Purpose  : Shared definitions for the common data bus (CDB) arbiter and
//             its consumers (reservation stations, order manager, regfile).
//             - default result / tag widths and requester count
//             - requester index constants (add, mul, div, load)
//             - cdb_bus_t broadcast record {valid, tag, data}
//  Revision : 1.0  initial release
// ============================================================================
package cdb_pkg;

    localparam int CDB_N_REQ  = 4;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 4;

    // Requester slot indices on the arbiter
    localparam int REQ_ADD  = 0;
    localparam int REQ_MUL  = 1;
    localparam int REQ_DIV  = 2;
    localparam int REQ_LOAD = 3;

    // One broadcast beat as seen by every CDB listener
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

endpackage : cdb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. Grants the first asserted
//             request at or after the pointer, searching upward and wrapping
//             from N_REQ-1 back to 0. At most one grant is produced.
//  Ports    : i_req    in   N_REQ   request vector (slot full flags)
//             i_ptr    in   IDX_W   highest-priority index this cycle
//             o_grant  out  N_REQ   one-hot grant (all zero when idle)
//             o_idx    out  IDX_W   index of the granted request
//             o_any    out  1       a grant was issued
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter  int N_REQ = CDB_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk the ring starting at the pointer; first hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(i_ptr) + k) % N_REQ;
            if (!o_any && i_req[j]) begin
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Shares the single common data bus among the functional units
//             (0=add, 1=mul, 2=div, 3=load). Each requester owns a 1-entry
//             holding slot so it can retire and restart without waiting for
//             the bus; a round-robin pick broadcasts one {tag,data} per cycle.
//  Ports    : clk        in   1             rising-edge clock
//             rst        in   1             synchronous reset, active-high
//             flush      in   1             (CDB_FLUSH_EN only) drop all slots
//             req_valid  in   N_REQ         requester i has a result
//             req_tag    in   N_REQ*TAG_W   tag i at [i*TAG_W +: TAG_W]
//             req_data   in   N_REQ*DATA_W  data i at [i*DATA_W +: DATA_W]
//             req_ready  out  N_REQ         slot i accepts this cycle
//             cdb_valid  out  1             broadcast valid (one cycle/result)
//             cdb_tag    out  TAG_W         broadcast tag
//             cdb_data   out  DATA_W        broadcast value
//             cdb_src    out  IDX_W         index of granted requester
//  Macro    : CDB_FLUSH_EN  adds the flush input (mispredict recovery)
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int N_REQ  = CDB_N_REQ,
    parameter  int DATA_W = CDB_DATA_W,
    parameter  int TAG_W  = CDB_TAG_W,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef CDB_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [IDX_W-1:0]        cdb_src
);

    // Holding slots
    logic [N_REQ-1:0]  r_full;
    logic [TAG_W-1:0]  r_slot_tag  [N_REQ];
    logic [DATA_W-1:0] r_slot_data [N_REQ];

    // Arbitration state and registered broadcast
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [IDX_W-1:0]  r_cdb_src;

    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_grant_any;
    logic [N_REQ-1:0]  w_ready;
    logic [N_REQ-1:0]  w_accept;
    logic [IDX_W-1:0]  w_next_ptr;
    logic              w_flush;

`ifdef CDB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ   (N_REQ)
    ) u_rr_arbiter (
        .i_req   (r_full),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // A slot can take a new result when empty, or when it is being drained
    // onto the bus this very edge. Depends only on slot state, never on
    // req_valid, so producers see no combinational loop through the arbiter.
    assign w_ready  = w_flush ? '0 : (~r_full | w_grant);
    assign w_accept = req_valid & w_ready;

    assign w_next_ptr = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                           : w_grant_idx + 1'b1;

    // Slot payload needs no reset: it is only observed while r_full is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_accept[i]) begin
                r_slot_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                r_slot_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= '0;
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else if (w_flush) begin
            // Squash everything in flight; pointer keeps its position.
            r_full      <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            // Accept wins over the drain so a same-edge refill stays full.
            r_full      <= (r_full & ~w_grant) | w_accept;
            r_cdb_valid <= w_grant_any;
            if (w_grant_any) begin
                r_cdb_tag  <= r_slot_tag[w_grant_idx];
                r_cdb_data <= r_slot_data[w_grant_idx];
                r_cdb_src  <= w_grant_idx;
                r_rr_ptr   <= w_next_ptr;
            end
        end
    end

    assign req_ready = w_ready;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter. Directed stimulus pushes
//             the expected broadcasts {src,tag,data,cycle} into a scoreboard;
//             a negedge monitor pops and compares each CDB beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic [N_REQ-1:0]        req_valid;
    logic [TAG_W-1:0]        tag_in  [N_REQ];
    logic [DATA_W-1:0]       data_in [N_REQ];
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [1:0]              cdb_src;

    assign req_tag  = {tag_in[3], tag_in[2], tag_in[1], tag_in[0]};
    assign req_data = {data_in[3], data_in[2], data_in[1], data_in[0]};

    cdb_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CDB_FLUSH_EN
        .flush     (flush),
`endif
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  src;
        logic [3:0]  tag;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int src, input int tag, input logic [31:0] data, input int c);
        exp_t e;
        e.src  = 2'(src);
        e.tag  = 4'(tag);
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every broadcast beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && cdb_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_bcast: got src=%0d tag=%0h cyc=%0d expected no broadcast",
                       cdb_src, cdb_tag, cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("bcast_src",  32'(cdb_src), 32'(e.src));
                check("bcast_tag",  32'(cdb_tag), 32'(e.tag));
                check("bcast_data", cdb_data,     e.data);
                check("bcast_cyc",  32'(cyc),     32'(e.cyc));
            end
        end
    end

    initial begin
        int c;
        // ---------------- 1: reset with all requesters valid
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < N_REQ; i++) begin
            tag_in[i]  = 4'(i + 8);
            data_in[i] = 32'h5555_0000 + 32'(i);
        end
        ticks(2);
        check("rst_ready",     32'(req_ready), 32'hF);
        check("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("rst_cdb_tag",   32'(cdb_tag),   32'h0);
        check("rst_cdb_data",  cdb_data,       32'h0);
        check("rst_cdb_src",   32'(cdb_src),   32'h0);
        req_valid = 4'h0;
        rst       = 1'b0;
        ticks(3);
        check("idle_cdb_valid", 32'(cdb_valid), 32'h0);

        // ---------------- 2: single request on mul
        c          = cyc;
        req_valid  = 4'b0010;
        tag_in[1]  = 4'd5;
        data_in[1] = 32'hDEAD_BEEF;
        push(1, 5, 32'hDEAD_BEEF, c + 2);
        tick();
        req_valid = 4'h0;
        ticks(4);

        // ---------------- 3: round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_cdb_valid", 32'(cdb_valid), 32'h0);
        c = cyc;
        req_valid = 4'hF;
        for (int i = 0; i < N_REQ; i++) begin
            tag_in[i]  = 4'(i + 1);
            data_in[i] = 32'hA000_0000 + 32'(i);
            push(i, i + 1, 32'hA000_0000 + 32'(i), c + 2 + i);
        end
        tick();
        req_valid = 4'h0;
        ticks(5);
        // pointer is back at 0: refill 0 and 2
        c = cyc;
        req_valid  = 4'b0101;
        tag_in[0]  = 4'hD;
        data_in[0] = 32'h0000_1234;
        tag_in[2]  = 4'h0;
        data_in[2] = 32'h0000_5678;
        push(0, 4'hD, 32'h0000_1234, c + 2);
        push(2, 4'h0, 32'h0000_5678, c + 3);
        tick();
        req_valid = 4'h0;
        ticks(4);

        // ---------------- 4: back-to-back from load
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            req_valid  = 4'b1000;
            tag_in[3]  = 4'(7 + k);
            data_in[3] = 32'h3000_0000 + 32'(k);
            push(3, 7 + k, 32'h3000_0000 + 32'(k), c + 2 + k);
            check("b2b_ready3", 32'(req_ready[3]), 32'h1);
            tick();
        end
        req_valid = 4'h0;
        ticks(4);

        // ---------------- 5: fairness with 0/1 permanently full, 2 mid-stream
        c = cyc;
        req_valid  = 4'b0011;
        tag_in[0]  = 4'hA;
        data_in[0] = 32'h0A0A_0A0A;
        tag_in[1]  = 4'hB;
        data_in[1] = 32'h0B0B_0B0B;
        tag_in[2]  = 4'hC;
        data_in[2] = 32'h0C0C_0C0C;
        push(0, 4'hA, 32'h0A0A_0A0A, c + 2);
        push(1, 4'hB, 32'h0B0B_0B0B, c + 3);
        push(0, 4'hA, 32'h0A0A_0A0A, c + 4);
        push(1, 4'hB, 32'h0B0B_0B0B, c + 5);
        push(2, 4'hC, 32'h0C0C_0C0C, c + 6);
        push(0, 4'hA, 32'h0A0A_0A0A, c + 7);
        push(1, 4'hB, 32'h0B0B_0B0B, c + 8);
        push(0, 4'hA, 32'h0A0A_0A0A, c + 9);
        ticks(3);
        req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        ticks(3);
        req_valid = 4'h0;
        ticks(4);

`ifdef CDB_FLUSH_EN
        // ---------------- 6: flush drops held results
        req_valid = 4'b0111;
        tick();
        flush     = 1'b1;
        req_valid = 4'b0001;
        check("flush_ready", 32'(req_ready), 32'h0);
        tick();
        flush      = 1'b0;
        c          = cyc;
        req_valid  = 4'b1000;
        tag_in[3]  = 4'hE;
        data_in[3] = 32'hCAFE_F00D;
        check("post_flush_ready", 32'(req_ready), 32'hF);
        push(3, 4'hE, 32'hCAFE_F00D, c + 2);
        tick();
        req_valid = 4'h0;
        ticks(4);
`endif

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
